// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension, writeback mux and stall hold buffer.
// Optional retired-instruction counter is enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             START,
    input  logic             FLUSH,
    input  logic             MEM_in_valid,
    input  logic [31:0]      MEM_in_instr,
    input  logic [XLEN-1:0]  MEM_in_ALU_res,
    input  logic [XLEN-1:0]  MEM_in_pc4,
    input  logic             MEM_in_RegWrite,
    input  logic             MEM_in_MemToReg,
    input  logic             MEM_in_Link,
    input  logic [XLEN-1:0]  MEM_mem_data,
    output logic             WB_rf_we,
    output logic [RF_AW-1:0] WB_rf_addr,
    output logic [XLEN-1:0]  WB_rf_data,
    output logic             WB_load_err,
    output logic [31:0]      WB_instr,
    output logic [CNT_W-1:0] WB_retire_cnt,
    output logic             dbg_hold_state
);

    typedef enum logic {LIVE = 1'b0, HELD = 1'b1} hold_state_t;

    // An instruction moves from MEM into WB only on an edge where EN and START are both high.
    logic advance;
    assign advance = EN & START;

    logic            wb_valid;
    logic [31:0]     wb_instr_q;
    logic [XLEN-1:0] wb_alu;
    logic [XLEN-1:0] wb_pc4;
    logic            wb_regwrite;
    logic            wb_memtoreg;
    logic            wb_link;

    hold_state_t     state, state_next;
    logic [XLEN-1:0] hold_reg, hold_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid    <= 1'b0;
            wb_instr_q  <= '0;
            wb_alu      <= '0;
            wb_pc4      <= '0;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_link     <= 1'b0;
        end else if (FLUSH) begin
            wb_valid <= 1'b0;
        end else if (advance) begin
            wb_valid    <= MEM_in_valid;
            wb_instr_q  <= MEM_in_instr;
            wb_alu      <= MEM_in_ALU_res;
            wb_pc4      <= MEM_in_pc4;
            wb_regwrite <= MEM_in_RegWrite;
            wb_memtoreg <= MEM_in_MemToReg;
            wb_link     <= MEM_in_Link;
        end
    end

    logic [1:0]      wb_off;
    logic [2:0]      funct3;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] fmt_live;
    logic            fmt_err;

    assign wb_off   = wb_alu[1:0];
    assign funct3   = wb_instr_q[14:12];
    assign byte_sel = MEM_mem_data[{wb_off, 3'b000} +: 8];
    assign half_sel = MEM_mem_data[{wb_off[1], 4'b0000} +: 16];

    always_comb begin
        fmt_live = '0;
        fmt_err  = 1'b0;
        case (funct3)
            3'b000: fmt_live = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: fmt_live = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001: begin
                fmt_live = {{(XLEN-16){half_sel[15]}}, half_sel};
                fmt_err  = wb_off[0];
            end
            3'b101: begin
                fmt_live = {{(XLEN-16){1'b0}}, half_sel};
                fmt_err  = wb_off[0];
            end
            3'b010: begin
                fmt_live = MEM_mem_data;
                fmt_err  = |wb_off;
            end
            default: fmt_err = 1'b1;
        endcase
    end

    // The memory output is only valid during the first WB cycle, so a stalled load
    // freezes its formatted value in hold_reg for the rest of the stall.
    always_comb begin
        state_next = state;
        hold_next  = hold_reg;
        if (FLUSH || advance) begin
            state_next = LIVE;
        end else if (state == LIVE && wb_valid && wb_memtoreg) begin
            state_next = HELD;
            hold_next  = fmt_live;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= LIVE;
            hold_reg <= '0;
        end else begin
            state    <= state_next;
            hold_reg <= hold_next;
        end
    end

    logic [XLEN-1:0] load_data;
    assign load_data = (state == HELD) ? hold_reg : fmt_live;

    always_comb begin
        if (wb_link)
            WB_rf_data = wb_pc4;
        else if (wb_memtoreg)
            WB_rf_data = load_data;
        else
            WB_rf_data = wb_alu;
    end

    assign WB_load_err    = wb_valid & wb_memtoreg & fmt_err;
    assign WB_rf_addr     = wb_instr_q[7 +: RF_AW];
    assign WB_rf_we       = wb_valid & wb_regwrite & (|WB_rf_addr) & ~WB_load_err;
    assign WB_instr       = wb_instr_q;
    assign dbg_hold_state = state;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
    always_ff @(posedge CLK) begin
        if (RST)
            retire_cnt <= '0;
        else if (wb_valid && advance && !FLUSH)
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    assign WB_retire_cnt = retire_cnt;
`else
    assign WB_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: reset, table of single-instruction vectors, then stall, flush, reset and counter sequences.
module tb_wb_stage;

    logic        CLK = 1'b0;
    logic        RST, EN, START, FLUSH;
    logic        MEM_in_valid;
    logic [31:0] MEM_in_instr, MEM_in_ALU_res, MEM_in_pc4;
    logic        MEM_in_RegWrite, MEM_in_MemToReg, MEM_in_Link;
    logic [31:0] MEM_mem_data;
    logic        WB_rf_we;
    logic [4:0]  WB_rf_addr;
    logic [31:0] WB_rf_data;
    logic        WB_load_err;
    logic [31:0] WB_instr;
    logic [63:0] WB_retire_cnt;
    logic        dbg_hold_state;

    wb_stage dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .FLUSH(FLUSH),
        .MEM_in_valid(MEM_in_valid), .MEM_in_instr(MEM_in_instr),
        .MEM_in_ALU_res(MEM_in_ALU_res), .MEM_in_pc4(MEM_in_pc4),
        .MEM_in_RegWrite(MEM_in_RegWrite), .MEM_in_MemToReg(MEM_in_MemToReg),
        .MEM_in_Link(MEM_in_Link), .MEM_mem_data(MEM_mem_data),
        .WB_rf_we(WB_rf_we), .WB_rf_addr(WB_rf_addr), .WB_rf_data(WB_rf_data),
        .WB_load_err(WB_load_err), .WB_instr(WB_instr),
        .WB_retire_cnt(WB_retire_cnt), .dbg_hold_state(dbg_hold_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        rw;
        logic        mtr;
        logic        link;
        logic [31:0] mem;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_err;
        logic        chk_data;
    } vec_t;

    // scoreboard entry: {chk_data, we, addr[4:0], data[31:0], err}
    logic [39:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [2:0] f3);
        return {12'h000, 5'd0, f3, rd, 7'b0000011};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [39:0] e;
        logic [38:0] act;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no expected entry expected one queued", name);
        end else begin
            e   = exp_q.pop_front();
            act = {WB_rf_we, WB_rf_addr, WB_rf_data, WB_load_err};
            if (!e[39]) begin
                act[32:1] = '0;
                e[32:1]   = '0;
            end
            check(name, {25'd0, act}, {25'd0, e[38:0]});
        end
    endtask

    // driver tasks
    task automatic drive_instr(input logic valid, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] pc4,
                               input logic rw, input logic mtr, input logic link);
        MEM_in_valid    = valid;
        MEM_in_instr    = mk_instr(rd, f3);
        MEM_in_ALU_res  = alu;
        MEM_in_pc4      = pc4;
        MEM_in_RegWrite = rw;
        MEM_in_MemToReg = mtr;
        MEM_in_Link     = link;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    {63'd0, WB_rf_we}, 64'd0);
        check({tag, "_addr"},  {59'd0, WB_rf_addr}, 64'd0);
        check({tag, "_data"},  {32'd0, WB_rf_data}, 64'd0);
        check({tag, "_err"},   {63'd0, WB_load_err}, 64'd0);
        check({tag, "_instr"}, {32'd0, WB_instr}, 64'd0);
        check({tag, "_cnt"},   WB_retire_cnt, 64'd0);
        check({tag, "_state"}, {63'd0, dbg_hold_state}, 64'd0);
    endtask

    vec_t vec[18];

    initial begin
        vec[0]  = '{1'b1, 3'd0, 5'd5,  32'h0000_1234, 32'h4,   1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b1};
        vec[1]  = '{1'b1, 3'd0, 5'd6,  32'h0000_1003, 32'h8,   1'b1, 1'b1, 1'b0, 32'h80FF_0000, 1'b1, 5'd6,  32'hFFFF_FF80, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 3'd4, 5'd6,  32'h0000_1003, 32'h8,   1'b1, 1'b1, 1'b0, 32'h80FF_0000, 1'b1, 5'd6,  32'h0000_0080, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 3'd1, 5'd8,  32'h0000_2001, 32'hC,   1'b1, 1'b1, 1'b0, 32'h1122_3344, 1'b0, 5'd8,  32'h0,         1'b1, 1'b0};
        vec[4]  = '{1'b1, 3'd2, 5'd9,  32'h0000_2000, 32'h10,  1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b0, 1'b1};
        vec[5]  = '{1'b1, 3'd1, 5'd10, 32'h0000_2002, 32'h14,  1'b1, 1'b1, 1'b0, 32'h8001_1234, 1'b1, 5'd10, 32'hFFFF_8001, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 3'd5, 5'd10, 32'h0000_2002, 32'h18,  1'b1, 1'b1, 1'b0, 32'h8001_1234, 1'b1, 5'd10, 32'h0000_8001, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 3'd0, 5'd11, 32'h0000_3001, 32'h1C,  1'b1, 1'b1, 1'b0, 32'h0000_7F00, 1'b1, 5'd11, 32'h0000_007F, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 3'd2, 5'd12, 32'h0000_3002, 32'h20,  1'b1, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 5'd12, 32'h0,         1'b1, 1'b0};
        vec[9]  = '{1'b1, 3'd3, 5'd13, 32'h0000_3000, 32'h24,  1'b1, 1'b1, 1'b0, 32'h6666_6666, 1'b0, 5'd13, 32'h0,         1'b1, 1'b0};
        vec[10] = '{1'b1, 3'd0, 5'd0,  32'h0000_0055, 32'h28,  1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0000_0055, 1'b0, 1'b1};
        vec[11] = '{1'b1, 3'd2, 5'd1,  32'h0000_0200, 32'h104, 1'b1, 1'b1, 1'b1, 32'h0000_AAAA, 1'b1, 5'd1,  32'h0000_0104, 1'b0, 1'b1};
        vec[12] = '{1'b1, 3'd0, 5'd3,  32'h0000_0077, 32'h2C,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 5'd3,  32'h0000_0077, 1'b0, 1'b1};
        vec[13] = '{1'b1, 3'd5, 5'd14, 32'h0000_4000, 32'h30,  1'b1, 1'b1, 1'b0, 32'h1234_F00D, 1'b1, 5'd14, 32'h0000_F00D, 1'b0, 1'b1};
        vec[14] = '{1'b1, 3'd3, 5'd15, 32'h0000_ABCD, 32'h34,  1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 5'd15, 32'h0000_ABCD, 1'b0, 1'b1};
        vec[15] = '{1'b0, 3'd0, 5'd4,  32'h0000_0099, 32'h38,  1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 5'd4,  32'h0,         1'b0, 1'b0};
        vec[16] = '{1'b1, 3'd0, 5'd16, 32'h0000_5000, 32'h3C,  1'b1, 1'b1, 1'b0, 32'h0000_00FE, 1'b1, 5'd16, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vec[17] = '{1'b1, 3'd4, 5'd17, 32'h0000_5002, 32'h40,  1'b1, 1'b1, 1'b0, 32'h00AB_0000, 1'b1, 5'd17, 32'h0000_00AB, 1'b0, 1'b1};

        RST = 1'b1; EN = 1'b0; START = 1'b0; FLUSH = 1'b0;
        drive_instr(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        MEM_mem_data = 32'h1357_9BDF;

        // reset state: during reset and in the cycle after it
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("in_reset");
        RST = 1'b0;
        @(negedge CLK);
        check_all_zero("after_reset");

        // table vectors, one instruction per cycle with no stalls
        EN = 1'b1; START = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive_instr(vec[i].valid, vec[i].f3, vec[i].rd, vec[i].alu, vec[i].pc4,
                        vec[i].rw, vec[i].mtr, vec[i].link);
            exp_q.push_back({vec[i].chk_data, vec[i].e_we, vec[i].e_addr, vec[i].e_data, vec[i].e_err});
            @(posedge CLK);
            #1 MEM_mem_data = vec[i].mem;
            @(negedge CLK);
            sb_check($sformatf("vec%0d", i));
            if (i == 0)
                check("vec0_instr", {32'd0, WB_instr}, {32'd0, mk_instr(5'd5, 3'd0)});
        end

`ifndef WB_RETIRE_CNT_EN
        check("cnt_tied_zero", WB_retire_cnt, 64'd0);
`endif

        // START low blocks advance even with EN high
        START = 1'b0;
        drive_instr(1'b1, 3'd0, 5'd20, 32'h0000_0EEE, 32'h0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 5'd17, 32'h0000_00AB, 1'b0});
        @(posedge CLK);
        @(negedge CLK);
        sb_check("start_gate");
        START = 1'b1;

        // stalled load keeps its first-cycle data
        drive_instr(1'b1, 3'd2, 5'd7, 32'h0000_0300, 32'h0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 5'd7, 32'hCAFE_BABE, 1'b0});
        @(posedge CLK);
        #1 MEM_mem_data = 32'hCAFE_BABE;
        EN = 1'b0;
        @(negedge CLK);
        sb_check("stall0");
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back({1'b1, 1'b1, 5'd7, 32'hCAFE_BABE, 1'b0});
            @(posedge CLK);
            #1 MEM_mem_data = 32'h0;
            @(negedge CLK);
            sb_check($sformatf("stall%0d", k));
            check($sformatf("held_state%0d", k), {63'd0, dbg_hold_state}, 64'd1);
        end

        // flush with EN low while held
        FLUSH = 1'b1;
        @(posedge CLK);
        #1 FLUSH = 1'b0;
        @(negedge CLK);
        check("flush_we", {63'd0, WB_rf_we}, 64'd0);
        check("flush_state", {63'd0, dbg_hold_state}, 64'd0);

        // reset together with flush clears everything
        EN = 1'b1;
        drive_instr(1'b1, 3'd0, 5'd5, 32'h0000_1234, 32'h8, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check("pre_rst_we", {63'd0, WB_rf_we}, 64'd1);
        drive_instr(1'b1, 3'd2, 5'd9, 32'h0000_0400, 32'h8, 1'b1, 1'b1, 1'b0);
        RST = 1'b1; FLUSH = 1'b1;
        MEM_mem_data = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1 RST = 1'b0; FLUSH = 1'b0; EN = 1'b0;
        @(negedge CLK);
        check_all_zero("rst_flush");

`ifdef WB_RETIRE_CNT_EN
        // ten valid instructions retired by the advances that follow them
        EN = 1'b1;
        for (int n = 0; n < 10; n++) begin
            drive_instr(1'b1, 3'd0, 5'($urandom_range(1, 31)), 32'($urandom_range(0, 1000)),
                        32'h0, 1'b1, 1'b0, 1'b0);
            @(posedge CLK);
            @(negedge CLK);
        end
        drive_instr(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        EN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("retire_cnt", WB_retire_cnt, 64'd10);
`endif

        check("sb_drained", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
